// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NREQ
// valid/ready producers, with an optional burst lock of up to BURST beats.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 1,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [IDW+WIDTH-1:0]  fifo_din,
  output logic [IDW-1:0]        grant_id,
  output logic                  locked
);
  localparam int CW = $clog2(BURST + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t st;
  logic [IDW-1:0] last, owner, base, sel, idx;
  logic [CW-1:0] cnt;
  logic own_v, found, acc, done;
  assign locked = st == LOCKED;
  assign own_v = locked && req_valid[owner];
  assign base = locked ? owner : last;
  assign done = int'(cnt) + 1 == BURST;
  // Scan downward so the nearest requester after base wins; a releasing owner is skipped.
  always_comb begin
    found = 1'b0;
    sel = owner;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(base) + k) % NREQ);
      if (req_valid[idx] && !(locked && k == NREQ)) begin
        found = 1'b1;
        sel = idx;
      end
    end
    if (own_v) begin
      found = 1'b1;
      sel = owner;
    end
  end
  assign acc = found && !fifo_full && !rst;
  assign req_ready = acc ? NREQ'(1) << sel : '0;
  assign fifo_wr_en = acc;
  assign fifo_din = acc ? {sel, req_data[sel*WIDTH +: WIDTH]} : '0;
  assign grant_id = locked ? owner : last;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      last <= IDW'(NREQ - 1);
      owner <= '0;
      cnt <= '0;
    end else if (own_v) begin
      if (acc) begin
        cnt <= done ? '0 : cnt + CW'(1);
        st <= done ? IDLE : LOCKED;
        last <= done ? owner : last;
      end
    end else if (acc) begin
      st <= BURST == 1 ? IDLE : LOCKED;
      last <= BURST == 1 ? sel : last;
      owner <= BURST == 1 ? owner : sel;
      cnt <= BURST == 1 ? cnt : CW'(1);
    end else if (locked) begin
      st <= IDLE;
      last <= owner;
      cnt <= '0;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: three arbiters (BURST 1, 2, 4) on shared stimulus, checked
// against a grant model and a FIFO scoreboard.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] v;
  logic [31:0] d;
  logic full;
  logic [3:0] rdy [3];
  logic we [3];
  logic [9:0] din [3];
  logic [1:0] gid [3];
  logic lk [3];
  int checks = 0, errors = 0;
  int m_last [3], m_owner [3], m_cnt [3];
  bit m_lock [3];
  int gl [3], obs_id [3], obs_gid [3], obs_lk [3];
  bit fifo_mode = 0;
  logic [9:0] f_act [$], f_exp [$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .BURST(1)) u_b1 (
    .clk(clk), .rst(rst), .req_valid(v), .req_data(d), .req_ready(rdy[0]), .fifo_full(full),
    .fifo_wr_en(we[0]), .fifo_din(din[0]), .grant_id(gid[0]), .locked(lk[0]));
  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .BURST(2)) u_b2 (
    .clk(clk), .rst(rst), .req_valid(v), .req_data(d), .req_ready(rdy[1]), .fifo_full(full),
    .fifo_wr_en(we[1]), .fifo_din(din[1]), .grant_id(gid[1]), .locked(lk[1]));
  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .BURST(4)) u_b4 (
    .clk(clk), .rst(rst), .req_valid(v), .req_data(d), .req_ready(rdy[2]), .fifo_full(full),
    .fifo_wr_en(we[2]), .fifo_din(din[2]), .grant_id(gid[2]), .locked(lk[2]));

  function automatic int bur(int i);
    return i == 0 ? 1 : (i == 1 ? 2 : 4);
  endfunction

  // Grant the owner while it keeps valid, else the first valid requester after the pointer.
  function automatic int expg(int i);
    int b;
    if (rst) return -1;
    if (m_lock[i] && v[m_owner[i]]) return full ? -1 : m_owner[i];
    if (full) return -1;
    b = m_lock[i] ? m_owner[i] : m_last[i];
    for (int k = 1; k <= (m_lock[i] ? 3 : 4); k++)
      if (v[(b + k) % 4]) return (b + k) % 4;
    return -1;
  endfunction

  task automatic model_step(int i, int g);
    if (rst) begin
      m_last[i] = 3; m_owner[i] = 0; m_cnt[i] = 0; m_lock[i] = 0;
    end else if (m_lock[i] && v[m_owner[i]]) begin
      if (g >= 0) begin
        m_cnt[i]++;
        if (m_cnt[i] == bur(i)) begin m_lock[i] = 0; m_last[i] = m_owner[i]; m_cnt[i] = 0; end
      end
    end else if (g >= 0) begin
      if (bur(i) == 1) m_last[i] = g;
      else begin m_lock[i] = 1; m_owner[i] = g; m_cnt[i] = 1; end
    end else if (m_lock[i]) begin
      m_lock[i] = 0; m_last[i] = m_owner[i]; m_cnt[i] = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] vv, input logic [31:0] dd, input logic ff, input logic rr);
    logic [9:0] e;
    v = vv; d = dd; rst = rr;
    full = fifo_mode ? (f_act.size() >= 4) : ff;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      gl[i] = expg(i);
      e = '0;
      if (gl[i] >= 0) e = {2'(gl[i]), d[gl[i]*8 +: 8]};
      obs_id[i] = we[i] === 1'b1 ? int'(din[i][9:8]) : -1;
      obs_gid[i] = int'(gid[i]);
      obs_lk[i] = int'(lk[i]);
      chk($sformatf("ready%0d", i), 32'(rdy[i]), gl[i] >= 0 ? 32'(1) << gl[i] : 32'(0));
      chk($sformatf("wr_en%0d", i), 32'(we[i]), 32'(gl[i] >= 0));
      if (!rr) begin
        chk($sformatf("din%0d", i), 32'(din[i]), 32'(e));
        chk($sformatf("locked%0d", i), 32'(lk[i]), 32'(m_lock[i]));
        chk($sformatf("grant_id%0d", i), 32'(gid[i]), 32'(m_lock[i] ? m_owner[i] : m_last[i]));
      end
      if (fifo_mode && i == 0) begin
        if (we[0] === 1'b1) f_act.push_back(din[0]);
        if (gl[0] >= 0) f_exp.push_back(e);
      end
      model_step(i, gl[i]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; v = '0; d = '0; full = 1'b0;
    repeat (2) cyc(4'hF, 32'h44332211, 1'b0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      cyc(4'hF, $urandom, 1'b0, 1'b0);
      chk("rr_order", 32'(obs_id[0]), 32'(n % 4));
      chk("b2_order", 32'(obs_id[1]), 32'(n / 2));
      chk("b4_order", 32'(obs_id[2]), 32'(n / 4));
      chk("b2_locked", 32'(obs_lk[1]), 32'(n % 2));
      if (n % 2 == 1) chk("b2_gid", 32'(obs_gid[1]), 32'(n / 2));
    end
    cyc(4'hF, $urandom, 1'b0, 1'b1);
    repeat (3) cyc(4'hF, $urandom, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      cyc(4'hF, $urandom, 1'b1, 1'b0);
      chk("stall_id", 32'(obs_id[1]), 32'(-1));
      chk("stall_locked", 32'(obs_lk[1]), 32'(1));
      chk("stall_gid", 32'(obs_gid[1]), 32'(1));
    end
    cyc(4'hF, $urandom, 1'b0, 1'b0);
    chk("stall_resume", 32'(obs_id[1]), 32'(1));
    cyc(4'hF, $urandom, 1'b0, 1'b0);
    chk("stall_next", 32'(obs_id[1]), 32'(2));
    cyc(4'hF, $urandom, 1'b0, 1'b1);
    cyc(4'hF, $urandom, 1'b0, 1'b0);
    cyc(4'b0100, $urandom, 1'b0, 1'b0);
    chk("drop_id", 32'(obs_id[2]), 32'(2));
    for (int n = 0; n < 3; n++) begin
      cyc(4'hF, $urandom, 1'b0, 1'b0);
      chk("drop_locked", 32'(obs_lk[2]), 32'(1));
      chk("drop_gid", 32'(obs_gid[2]), 32'(2));
      chk("drop_beat", 32'(obs_id[2]), 32'(2));
    end
    cyc(4'hF, $urandom, 1'b0, 1'b0);
    chk("drop_after", 32'(obs_id[2]), 32'(3));
    cyc(4'hF, $urandom, 1'b0, 1'b1);
    chk("rst_mid_wr", 32'(obs_id[2]), 32'(-1));
    cyc(4'h0, $urandom, 1'b0, 1'b0);
    chk("rst_mid_locked", 32'(obs_lk[2]), 32'(0));
    chk("rst_mid_gid", 32'(obs_gid[2]), 32'(3));
    fifo_mode = 1;
    f_act.delete(); f_exp.delete();
    repeat (8) cyc(4'hF, $urandom, 1'b0, 1'b0);
    chk("fifo_words", 32'(f_act.size()), 32'(4));
    chk("fifo_exp_words", 32'(f_exp.size()), 32'(4));
    for (int k = 0; k < f_act.size() && k < f_exp.size(); k++)
      chk($sformatf("fifo_word%0d", k), 32'(f_act[k]), 32'(f_exp[k]));
    void'(f_act.pop_front());
    cyc(4'hF, $urandom, 1'b0, 1'b0);
    chk("fifo_after_pop", 32'(obs_id[0] >= 0), 32'(1));
    fifo_mode = 0;
    repeat (400)
      cyc(4'($urandom), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
